md_issue_ctrl: RTL
==================

# md_issue_ctrl

- Sits in the EX stage between the ID/EX pipeline register and the multiply/divide unit (MD).
- Accepts an MD instruction from EX, registers its operands and operation code, and presents the operation to MD for exactly one cycle, so MD never re-triggers and never recomputes HI/LO from changing operands.
- Raises a pipeline stall on structural hazards and on mfhi/mflo until the read value is captured.
- Returns HI/LO read data to EX.

## Interface

Parameters:
- none (widths fixed: 32-bit data, 5-bit MD operation code)

Ports:
- CLK  in  1  pipeline clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- EXMDOp  in  5  MD operation of the instruction in EX. Codes: 00101 multu, 00110 mult, 00111 divu, 01000 div, 01001 mfhi, 01010 mflo, 01011 mthi, 01100 mtlo. Any other value means no MD op.
- EXOperandA  in  32  forwarded rs value
- EXOperandB  in  32  forwarded rt value
- MDBusy  in  1  busy flag from MD
- MDResult  in  32  HI/LO read value from MD
- MDOperand1  out  32  registered operand to MD (rs)
- MDOperand2  out  32  registered operand to MD (rt)
- MDOperation  out  5  registered operation to MD; nonzero only in ISSUE
- MDStall  out  1  combinational; freezes IF/ID/EX when 1
- MDReadData  out  32  captured mfhi/mflo value
- MDReadValid  out  1  high for the single cycle MDReadData is valid for EX

## Operation

- Op classes:
  - arith: codes 00101–01000
  - write: 01011, 01100
  - read: 01001, 01010
  - mdop: any of the above
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - Accept when mdop && !MDBusy.
  - Latch EXOperandA/B into MDOperand1/2 and EXMDOp into MDOperation; go to ISSUE.
  - If mdop && MDBusy: stall, do not accept.
- ISSUE (MDOperation = latched code):
  - arith → WAIT.
  - write → IDLE.
  - read → capture MDResult into MDReadData → DONE.
  - MDOperation clears to 0 on every exit from ISSUE.
- WAIT: MDOperation = 0. Go to IDLE on the first edge where MDBusy = 0.
- DONE: MDReadValid = 1; go to IDLE unconditionally. Never accepts in DONE, so an mfhi still held in EX is not re-issued.
- MDStall:
  - IDLE: 1 iff (mdop && MDBusy) || (read && accepting)
  - ISSUE: 1 iff mdop in EX
  - WAIT: 1 iff mdop in EX
  - DONE: 0
- arith and write do not stall on acceptance; EX advances in the accept cycle (non-blocking multiply/divide).
- MDOperand1/2 hold their value in all states except at acceptance.
- Reset values: MDOperation 0, MDOperand1/2 0, MDReadData 0, MDReadValid 0; MDStall follows its IDLE equation.
- Reset mid-operation returns the FSM to IDLE immediately. MD has no reset, so it may remain busy; the MDBusy gating in IDLE makes this safe.

## Timing

- Accept at edge E0.
- ISSUE occupies cycle c1; MD samples the start at edge E1.
- arith: WAIT from c2. MDBusy is already 1 in c2. FSM returns to IDLE the edge after MDBusy is seen 0. The next mdop is accepted no earlier than that IDLE cycle.
- write: HI/LO are updated combinationally by MD during c1; back in IDLE in c2. A following mdop in c1 stalls one cycle.
- read: MDStall = 1 in c0 and c1; MDReadValid = 1 with MDStall = 0 in c2. Total mfhi/mflo latency is 2 stall cycles.
- MDOperation is nonzero for exactly one cycle per accepted op.

## Test plan

- After Reset: all outputs 0. EXMDOp = 00110 with A = 0xFFFFFFFE, B = 3 → MDOperation = 00110 for exactly one cycle, MDStall = 0 in the accept cycle. A subsequent mflo returns MDReadData = 0xFFFFFFFA with MDReadValid one cycle.
- divu 100 / 7 immediately followed by mfhi: MDStall stays 1 while MDBusy = 1, then MDReadData = 2 (HI = remainder) and MDStall drops in the MDReadValid cycle.
- mthi 0x12345678 then mfhi back-to-back: mfhi stalls 1 cycle for ISSUE, then 2 read cycles; MDReadData = 0x12345678.
- Non-MD op (EXMDOp = 0) while WAIT with MDBusy = 1: MDStall = 0, no state change.
- Reset asserted during WAIT: next cycle IDLE, MDOperation = 0. An mult presented while external MDBusy is still 1 is stalled until MDBusy = 0.
- mfhi held in EX through DONE: exactly one MDOperation = 01001 pulse, no re-issue.

Source files
------------

// File: rtl/md_issue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : md_issue_ctrl
// Purpose  : EX-stage issue controller for the multiply/divide unit.
//            Presents each MD op once, stalls on hazards and returns HI/LO reads.
// Revision : 1.0 - initial release
// ============================================================================
module md_issue_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [4:0]  EXMDOp,
    input  logic [31:0] EXOperandA,
    input  logic [31:0] EXOperandB,
    input  logic        MDBusy,
    input  logic [31:0] MDResult,
    output logic [31:0] MDOperand1,
    output logic [31:0] MDOperand2,
    output logic [4:0]  MDOperation,
    output logic        MDStall,
    output logic [31:0] MDReadData,
    output logic        MDReadValid
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [4:0] c_OP_ARITH_LO = 5'b00101;
    localparam logic [4:0] c_OP_ARITH_HI = 5'b01000;
    localparam logic [4:0] c_OP_MFHI     = 5'b01001;
    localparam logic [4:0] c_OP_MFLO     = 5'b01010;
    localparam logic [4:0] c_OP_MTHI     = 5'b01011;
    localparam logic [4:0] c_OP_MTLO     = 5'b01100;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_ex_arith;
    logic       w_ex_write;
    logic       w_ex_read;
    logic       w_ex_mdop;
    logic       w_accept;
    logic       w_iss_arith;
    logic       w_iss_read;

    assign w_ex_arith  = (EXMDOp >= c_OP_ARITH_LO) && (EXMDOp <= c_OP_ARITH_HI);
    assign w_ex_write  = (EXMDOp == c_OP_MTHI) || (EXMDOp == c_OP_MTLO);
    assign w_ex_read   = (EXMDOp == c_OP_MFHI) || (EXMDOp == c_OP_MFLO);
    assign w_ex_mdop   = w_ex_arith || w_ex_write || w_ex_read;
    assign w_accept    = (r_state == c_IDLE) && w_ex_mdop && !MDBusy;

    assign w_iss_arith = (MDOperation >= c_OP_ARITH_LO) && (MDOperation <= c_OP_ARITH_HI);
    assign w_iss_read  = (MDOperation == c_OP_MFHI) || (MDOperation == c_OP_MFLO);

    assign MDReadValid = (r_state == c_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_ISSUE;
            c_ISSUE: begin
                if (w_iss_arith)     w_state_nxt = c_WAIT;
                else if (w_iss_read) w_state_nxt = c_DONE;
                else                 w_state_nxt = c_IDLE;
            end
            c_WAIT:  if (!MDBusy) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // DONE never stalls, so the read held in EX retires without being re-accepted.
    always_comb begin
        MDStall = 1'b0;
        case (r_state)
            c_IDLE:          MDStall = (w_ex_mdop && MDBusy) || (w_ex_read && w_accept);
            c_ISSUE, c_WAIT: MDStall = w_ex_mdop;
            default:         MDStall = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= c_IDLE;
            MDOperation <= 5'd0;
            MDOperand1  <= 32'd0;
            MDOperand2  <= 32'd0;
            MDReadData  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            // Only the accept edge loads an op; every other edge clears it.
            MDOperation <= w_accept ? EXMDOp : 5'd0;
            if (w_accept) begin
                MDOperand1 <= EXOperandA;
                MDOperand2 <= EXOperandB;
            end
            if ((r_state == c_ISSUE) && w_iss_read) begin
                MDReadData <= MDResult;
            end
        end
    end

endmodule
`default_nettype wire
